// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: execute-side request, data-memory port and writeback result bundle
interface lsu_ctrl_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic            in_is_load;
    logic            in_is_store;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic [4:0]      in_rd;
    logic            mem_ld_en;
    logic            mem_st_en;
    logic [XLEN-1:0] mem_raddr;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rdata;
    logic [4:0]      out_rd;
    logic            out_is_load;
    logic            out_misalign;

    modport slave (
        input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
        output in_ready,
        output mem_ld_en, mem_st_en, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        input  mem_rdata,
        output out_valid, out_rdata, out_rd, out_is_load, out_misalign,
        input  out_ready
    );

    modport master (
        output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
        input  in_ready,
        input  mem_ld_en, mem_st_en, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        output mem_rdata,
        input  out_valid, out_rdata, out_rd, out_is_load, out_misalign,
        output out_ready
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store stage with lane shifting, load extension and misalign flagging
module lsu_ctrl #(parameter int XLEN = 32) (
    input logic       clock,
    input logic       reset,
    lsu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state, state_nx;
    logic            ld_q, st_q, mis_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [4:0]      rd_q;
    logic            mis_in, is_b, is_h, acc, st_en;
    logic [3:0]      lane;
    logic [XLEN-1:0] rsh, ext;

    assign mis_in = (bus.in_is_load | bus.in_is_store) &
                    ((bus.in_funct3[1:0] == 2'b01 & bus.in_addr[0]) | (bus.in_funct3[1] & |bus.in_addr[1:0]));
    assign is_b   = f3_q[1:0] == 2'b00;
    assign is_h   = f3_q[1:0] == 2'b01;
    assign acc    = state == ACCESS;
    assign st_en  = acc & st_q & ~ld_q;
    assign lane   = is_b ? 4'b0001 << addr_q[1:0] : is_h ? 4'b0011 << addr_q[1:0] : 4'b1111;
    assign rsh    = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    assign ext    = is_b ? {{24{~f3_q[2] & rsh[7]}}, rsh[7:0]} :
                    is_h ? {{16{~f3_q[2] & rsh[15]}}, rsh[15:0]} : bus.mem_rdata;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.in_valid ? (mis_in ? DONE : ACCESS) : IDLE;
            ACCESS:  state_nx = DONE;
            DONE:    state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // latch the accepted operation and capture the extended load result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            mis_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            ld_q    <= bus.in_is_load;
            st_q    <= bus.in_is_store;
            mis_q   <= mis_in;
            f3_q    <= bus.in_funct3;
            addr_q  <= bus.in_addr;
            wdata_q <= bus.in_wdata;
            rd_q    <= bus.in_rd;
            rdata_q <= '0;
        end else if (acc && ld_q) begin
            rdata_q <= ext;
        end
    end

    // outputs: handshakes, single-cycle enables and lane-shifted store data
    always_comb begin
        bus.in_ready     = state == IDLE;
        bus.out_valid    = state == DONE;
        bus.mem_ld_en    = acc & ld_q;
        bus.mem_st_en    = st_en;
        bus.mem_raddr    = {addr_q[XLEN-1:2], 2'b00};
        bus.mem_waddr    = {addr_q[XLEN-1:2], 2'b00};
        bus.mem_wdata    = is_b ? {4{wdata_q[7:0]}} : is_h ? {2{wdata_q[15:0]}} : wdata_q;
        bus.mem_wmask    = {4'b0000, lane & {4{st_en}}};
        bus.out_rdata    = rdata_q;
        bus.out_rd       = rd_q;
        bus.out_is_load  = ld_q;
        bus.out_misalign = mis_q;
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed load/store ops checked every cycle against a transaction-level model
module tb_lsu_ctrl;
    typedef struct {
        logic        mis;
        logic        ld;
        logic        st;
        logic        is_load;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } exp_t;

    logic clock = 0;
    logic reset = 1;
    int   checks = 0;
    int   errors = 0;
    int   nacc = 0;
    int   acc_n = 0;
    logic busy = 0;
    logic chk_en = 0;
    exp_t ex;

    lsu_ctrl_if bus();
    lsu_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endfunction

    function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [4:0] rd, input logic [31:0] mrd);
        exp_t   e;
        int     sz, off;
        longint v, lim;
        sz        = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
        off       = int'(a % 4);
        e.mis     = (ld || st) && (off % sz != 0);
        e.ld      = !e.mis && ld;
        e.st      = !e.mis && st && !ld;
        e.is_load = ld;
        e.rd      = rd;
        e.addr    = a - 32'(off);
        e.mask    = e.st ? 8'(((1 << sz) - 1) << off) : 8'h00;
        e.wdata   = sz == 1 ? 32'((wd % 256) * 32'h01010101) :
                    sz == 2 ? 32'((wd % 65536) * 32'h00010001) : wd;
        v = longint'({32'h0, mrd}) >> (8 * off);
        if (sz < 4) begin
            lim = longint'(1) << (8 * sz);
            v   = v % lim;
            if (!f3[2] && v >= lim / 2) v = v - lim;
        end
        e.rdata = e.ld ? 32'(v) : 32'h0;
        return e;
    endfunction

    // cycle-level compare against the current expected transaction
    always @(negedge clock) begin
        int   k;
        logic eacc, eov;
        if (chk_en) begin
            k    = nacc - acc_n;
            eacc = busy && k == 0 && !ex.mis;
            eov  = busy && (ex.mis || k >= 1);
            chk("in_ready", 32'(bus.in_ready), 32'(!busy));
            chk("out_valid", 32'(bus.out_valid), 32'(eov));
            chk("mem_ld_en", 32'(bus.mem_ld_en), 32'(eacc && ex.ld));
            chk("mem_st_en", 32'(bus.mem_st_en), 32'(eacc && ex.st));
            chk("mem_wmask", 32'(bus.mem_wmask), (eacc && ex.st) ? 32'(ex.mask) : 32'h0);
            if (eacc && ex.st) begin
                chk("mem_waddr", bus.mem_waddr, ex.addr);
                chk("mem_wdata", bus.mem_wdata, ex.wdata);
            end
            if (eacc && ex.ld) chk("mem_raddr", bus.mem_raddr, ex.addr);
            if (eov) begin
                chk("out_rdata", bus.out_rdata, ex.rdata);
                chk("out_rd", 32'(bus.out_rd), 32'(ex.rd));
                chk("out_is_load", 32'(bus.out_is_load), 32'(ex.is_load));
                chk("out_misalign", 32'(bus.out_misalign), 32'(ex.mis));
            end
        end
        nacc++;
    end

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        bus.in_valid    = 1;
        bus.in_is_load  = ld;
        bus.in_is_store = st;
        bus.in_funct3   = f3;
        bus.in_addr     = a;
        bus.in_wdata    = wd;
        bus.in_rd       = rd;
    endtask

    task automatic op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] mrd,
                      input int hold, input logic junk, input logic [31:0] lit);
        int n;
        drive(ld, st, f3, a, wd, rd);
        bus.mem_rdata = mrd;
        @(posedge clock);
        #1;
        acc_n = nacc;
        ex    = model(ld, st, f3, a, wd, rd, mrd);
        busy  = 1;
        bus.in_valid = 0;
        chk("model_rdata", ex.rdata, lit);
        if (junk) drive(1'b1, 1'b0, 3'b010, 32'h0, 32'hFFFFFFFF, 5'd31);
        n = 0;
        while (!bus.out_valid && n < 8) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("latency", 32'(n), ex.mis ? 32'd0 : 32'd1);
        chk("lit_rdata", bus.out_rdata, lit);
        repeat (hold) begin
            @(posedge clock);
            #1;
        end
        bus.in_valid  = 0;
        bus.out_ready = 1;
        @(posedge clock);
        #1;
        busy          = 0;
        bus.out_ready = 0;
    endtask

    initial begin
        exp_t m;
        bus.in_valid = 0; bus.in_is_load = 0; bus.in_is_store = 0; bus.in_funct3 = 0;
        bus.in_addr = 0; bus.in_wdata = 0; bus.in_rd = 0; bus.mem_rdata = 0; bus.out_ready = 0;
        ex = model(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        m = model(1'b0, 1'b1, 3'b000, 32'h80000103, 32'h000000A5, 5'd0, 32'h0);
        chk("model_sb_mask", 32'(m.mask), 32'h08);
        chk("model_sb_wdata", m.wdata, 32'hA5A5A5A5);
        chk("model_sb_addr", m.addr, 32'h80000100);
        m = model(1'b1, 1'b0, 3'b010, 32'h80000006, 32'h0, 5'd0, 32'h0);
        chk("model_lw_mis", 32'(m.mis), 32'h1);
        repeat (2) @(negedge clock);
        reset = 0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_enables", {30'h0, bus.mem_ld_en, bus.mem_st_en}, 32'h0);
        chk("rst_wmask", 32'(bus.mem_wmask), 32'h0);
        chk("rst_out_rdata", bus.out_rdata, 32'h0);
        chk("rst_out_flags", {25'h0, bus.out_rd, bus.out_is_load, bus.out_misalign}, 32'h0);
        chk_en = 1;
        op(1'b0, 1'b1, 3'b010, 32'h80000104, 32'hDEADBEEF, 5'd5,  32'h0,        0, 1'b0, 32'h0);
        op(1'b0, 1'b1, 3'b000, 32'h80000103, 32'h000000A5, 5'd6,  32'h0,        0, 1'b0, 32'h0);
        op(1'b1, 1'b0, 3'b000, 32'h80000102, 32'h0,        5'd7,  32'h12F03456, 0, 1'b0, 32'hFFFFFFF0);
        op(1'b1, 1'b0, 3'b100, 32'h80000102, 32'h0,        5'd8,  32'h12F03456, 0, 1'b0, 32'h000000F0);
        op(1'b1, 1'b0, 3'b101, 32'h80000102, 32'h0,        5'd9,  32'h12F03456, 0, 1'b0, 32'h000012F0);
        op(1'b1, 1'b0, 3'b010, 32'h80000006, 32'h0,        5'd10, 32'h55555555, 0, 1'b0, 32'h0);
        op(1'b1, 1'b0, 3'b001, 32'h80000102, 32'h0,        5'd11, 32'h80011234, 5, 1'b1, 32'hFFFF8001);
        op(1'b0, 1'b1, 3'b001, 32'h80000002, 32'h0000BEEF, 5'd12, 32'h0,        0, 1'b0, 32'h0);
        op(1'b0, 1'b1, 3'b001, 32'h80000001, 32'h0000BEEF, 5'd13, 32'h0,        2, 1'b0, 32'h0);
        op(1'b1, 1'b0, 3'b010, 32'h80000200, 32'h0,        5'd14, 32'hCAFEF00D, 0, 1'b0, 32'hCAFEF00D);
        op(1'b1, 1'b0, 3'b111, 32'h80000204, 32'h0,        5'd15, 32'h13572468, 0, 1'b0, 32'h13572468);
        op(1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0,        5'd16, 32'h7F000000, 0, 1'b0, 32'h0000007F);
        drive(1'b0, 1'b1, 3'b010, 32'h80000300, 32'h01234567, 5'd17);
        @(posedge clock);
        #1;
        acc_n = nacc;
        ex    = model(1'b0, 1'b1, 3'b010, 32'h80000300, 32'h01234567, 5'd17, 32'h0);
        busy  = 1;
        bus.in_valid = 0;
        @(negedge clock);
        #1;
        chk_en = 0;
        chk("pre_rst_st_en", 32'(bus.mem_st_en), 32'h1);
        reset = 1;
        #1;
        chk("rst_kill_en", {30'h0, bus.mem_ld_en, bus.mem_st_en}, 32'h0);
        chk("rst_kill_wmask", 32'(bus.mem_wmask), 32'h0);
        chk("rst_kill_valid", 32'(bus.out_valid), 32'h0);
        busy = 0;
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'h1);
        chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
        chk_en = 1;
        op(1'b1, 1'b0, 3'b101, 32'h80000000, 32'h0, 5'd18, 32'h0000ABCD, 0, 1'b0, 32'h0000ABCD);
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
